// File: rtl/freq_gate_counter.sv
// freq_gate_counter: gated-window frequency counter.
// Counts rising edges of the asynchronous i_sig over back-to-back windows of
// GATE_CYCLES clk cycles and publishes the count on o_freq with an o_valid pulse.
// Optional feature macro: FREQ_METER_BCD_EN adds o_freq_bcd and a sequential
// double-dabble converter; o_valid then lands with the BCD result.
module freq_gate_counter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned CNT_W       = 28,
  parameter int unsigned BCD_DIGITS  = 9
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_en,
  input  logic                  i_sig,
  output logic [CNT_W-1:0]      o_freq,
  output logic                  o_ovf,
  output logic                  o_valid,
  output logic                  o_busy
`ifdef FREQ_METER_BCD_EN
  ,
  output logic [4*BCD_DIGITS-1:0] o_freq_bcd
`endif
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic {ST_IDLE, ST_GATE} state_t;

  logic               r_s1;
  logic               r_s2;
  logic               r_s3;
  state_t             r_state;
  logic [GATE_W-1:0]  r_gate_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic               r_sat;
  logic [CNT_W-1:0]   r_freq;
  logic               r_ovf;
  logic               r_busy;
  logic               r_valid;

  logic               w_edge;
  logic               w_last;
  logic               w_sat_add;
  logic [CNT_W-1:0]   w_cnt_next;

  assign w_edge     = r_s2 & ~r_s3;
  assign w_last     = (r_state == ST_GATE) && (r_gate_cnt == GATE_LAST);
  assign w_sat_add  = w_edge && (r_edge_cnt == CNT_MAX);
  assign w_cnt_next = w_sat_add ? CNT_MAX : r_edge_cnt + CNT_W'(w_edge);

  // Synchronise i_sig into clk; s3 is the delayed copy for edge detection.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Window FSM: gate timing, saturating edge count and result publication.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_gate_cnt <= '0;
      r_edge_cnt <= '0;
      r_sat      <= 1'b0;
      r_freq     <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_gate_cnt <= '0;
          r_edge_cnt <= '0;
          r_sat      <= 1'b0;
          if (i_en) begin
            r_state <= ST_GATE;
            r_busy  <= 1'b1;
          end
        end
        ST_GATE: begin
          if (w_last) begin
            // Final cycle still counts its own edge; next window starts at once.
            r_freq     <= w_cnt_next;
            r_ovf      <= r_sat | w_sat_add;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
            if (!i_en) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else if (!i_en) begin
            // Abort: partial window dropped, published result untouched.
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_sat      <= 1'b0;
          end else begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            r_edge_cnt <= w_cnt_next;
            if (w_sat_add) begin
              r_sat <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FREQ_METER_BCD_EN
  localparam int unsigned BCD_W    = 4 * BCD_DIGITS;
  localparam int unsigned DD_W     = BCD_W + CNT_W;
  localparam int unsigned BIT_W    = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CNT_W - 1);

  typedef enum logic {CIDLE, SHIFT} cstate_t;

  cstate_t            r_cstate;
  logic [DD_W-1:0]    r_dd;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [BCD_W-1:0]   r_bcd_out;
  logic [DD_W-1:0]    w_dd_adj;
  logic [DD_W-1:0]    w_dd_shift;

  // Double-dabble add-3 step on every BCD digit held above the binary field.
  always_comb begin
    w_dd_adj = r_dd;
    for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
      if (r_dd[CNT_W + 4*d +: 4] >= 4'd5) begin
        w_dd_adj[CNT_W + 4*d +: 4] = r_dd[CNT_W + 4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_dd_shift = w_dd_adj << 1;

  // Converter: loads with o_freq, shifts CNT_W times, then issues BCD and o_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cstate  <= CIDLE;
      r_dd      <= '0;
      r_bit_cnt <= '0;
      r_bcd_out <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_last) begin
        r_dd      <= {BCD_W'(0), w_cnt_next};
        r_bit_cnt <= '0;
        r_cstate  <= SHIFT;
      end else begin
        case (r_cstate)
          SHIFT: begin
            r_dd      <= w_dd_shift;
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (r_bit_cnt == BIT_LAST) begin
              r_bcd_out <= w_dd_shift[DD_W-1 -: BCD_W];
              r_valid   <= 1'b1;
              r_cstate  <= CIDLE;
            end
          end
          default: begin
            r_cstate <= CIDLE;
          end
        endcase
      end
    end
  end

  assign o_freq_bcd = r_bcd_out;
`else
  // o_valid marks the first cycle the new o_freq/o_ovf are visible.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_last;
    end
  end
`endif

  assign o_freq  = r_freq;
  assign o_ovf   = r_ovf;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: a 1000-cycle / 28-bit instance for normal
// counting and a 100-cycle / 4-bit instance for saturation behaviour.
module tb_freq_gate_counter;

  localparam int unsigned GA  = 1000;
  localparam int unsigned CWA = 28;
  localparam int unsigned GB  = 100;
  localparam int unsigned CWB = 4;
  localparam int unsigned BD  = 9;
`ifdef FREQ_METER_BCD_EN
  localparam int LAT_A = CWA;
`else
  localparam int LAT_A = 0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic sig_a = 1'b0;
  logic sig_b = 1'b0;

  logic [CWA-1:0] freq_a;
  logic           ovf_a, valid_a, busy_a;
  logic [CWB-1:0] freq_b;
  logic           ovf_b, valid_b, busy_b;
`ifdef FREQ_METER_BCD_EN
  logic [4*BD-1:0] bcd_a;
  logic [4*BD-1:0] bcd_b;
`endif

  int total = 0;
  int bad = 0;

  // Period of the generated test signal: >0 square wave, 0 held low, <0 held high.
  int per_a = 0;
  int per_b = 0;
  int ph_a = 0;
  int ph_b = 0;

  always #5 clk = ~clk;

  freq_gate_counter #(.GATE_CYCLES(GA), .CNT_W(CWA), .BCD_DIGITS(BD)) u_dut (
    .clk(clk), .rstn(rstn), .i_en(en_a), .i_sig(sig_a),
    .o_freq(freq_a), .o_ovf(ovf_a), .o_valid(valid_a), .o_busy(busy_a)
`ifdef FREQ_METER_BCD_EN
    , .o_freq_bcd(bcd_a)
`endif
  );

  freq_gate_counter #(.GATE_CYCLES(GB), .CNT_W(CWB), .BCD_DIGITS(BD)) u_sat (
    .clk(clk), .rstn(rstn), .i_en(en_b), .i_sig(sig_b),
    .o_freq(freq_b), .o_ovf(ovf_b), .o_valid(valid_b), .o_busy(busy_b)
`ifdef FREQ_METER_BCD_EN
    , .o_freq_bcd(bcd_b)
`endif
  );

  // Signal generators for the two instances.
  always @(posedge clk) begin
    if (per_a <= 0) begin
      ph_a  <= 0;
      sig_a <= (per_a < 0);
    end else begin
      ph_a  <= (ph_a + 1 >= per_a) ? 0 : ph_a + 1;
      sig_a <= (ph_a < per_a / 2);
    end
  end

  always @(posedge clk) begin
    if (per_b <= 0) begin
      ph_b  <= 0;
      sig_b <= (per_b < 0);
    end else begin
      ph_b  <= (ph_b + 1 >= per_b) ? 0 : ph_b + 1;
      sig_b <= (ph_b < per_b / 2);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_valid(input bit sel, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      if ((sel ? valid_b : valid_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_valid sel=%0d: no o_valid within 3000 cycles, want a pulse", sel);
    end
  endtask

  typedef struct {
    bit sel;
    int per;
    int skip;
    int exp_f;
    bit exp_o;
  } vec_t;

  vec_t vt [12];

  initial begin
    bit ok;
    int n;
    int n_v;

    vt[0]  = '{1'b0,  10, 0, 100, 1'b0};
    vt[1]  = '{1'b0,  10, 0, 100, 1'b0};
    vt[2]  = '{1'b0,   0, 1,   0, 1'b0};
    vt[3]  = '{1'b0,  -1, 1,   0, 1'b0};
    vt[4]  = '{1'b0,  10, 1, 100, 1'b0};
    vt[5]  = '{1'b0,  20, 1,  50, 1'b0};
    vt[6]  = '{1'b0,   4, 1, 250, 1'b0};
    vt[7]  = '{1'b1,   4, 1,  15, 1'b1};
    vt[8]  = '{1'b1,  10, 1,  10, 1'b0};
    vt[9]  = '{1'b1,   0, 1,   0, 1'b0};
    vt[10] = '{1'b1,  20, 1,   5, 1'b0};
    vt[11] = '{1'b1,   4, 1,  15, 1'b1};

    per_a = 10;
    per_b = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_freq_a", 64'(freq_a), 0);
    chk("rst_ovf_a", 64'(ovf_a), 0);
    chk("rst_valid_a", 64'(valid_a), 0);
    chk("rst_busy_a", 64'(busy_a), 0);
    chk("rst_freq_b", 64'(freq_b), 0);
    chk("rst_busy_b", 64'(busy_b), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Idle with i_en low: nothing happens
    n_v = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      if (valid_a === 1'b1 || busy_a === 1'b1) n_v++;
    end
    chk("idle_quiet", 64'(n_v), 0);

    en_a = 1'b1;
    @(posedge clk);
    #1;
    chk("busy_after_en", 64'(busy_a), 1);

    // Table of windows
    for (int i = 0; i < 12; i++) begin
      if (vt[i].sel) begin
        per_b = vt[i].per;
        en_b  = 1'b1;
      end else begin
        per_a = vt[i].per;
      end
      for (int k = 0; k <= vt[i].skip; k++) wait_valid(vt[i].sel, ok);
      if (ok) begin
        chk($sformatf("vec%0d_freq", i), vt[i].sel ? 64'(freq_b) : 64'(freq_a), 64'(vt[i].exp_f));
        chk($sformatf("vec%0d_ovf", i), vt[i].sel ? 64'(ovf_b) : 64'(ovf_a), 64'(vt[i].exp_o));
      end
    end
    en_b = 1'b0;

    // Pulse width and window period on the main instance
    per_a = 10;
    wait_valid(1'b0, ok);
    wait_valid(1'b0, ok);
    @(posedge clk);
    #1;
    chk("valid_1cycle", 64'(valid_a), 0);
    n = 1;
    while (valid_a !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("valid_period", 64'(n), 64'(GA));
    chk("period_freq", 64'(freq_a), 100);
`ifdef FREQ_METER_BCD_EN
    chk("bcd_100", 64'(bcd_a), 64'h000000100);
`endif

    // Abort mid-window
    repeat (500) @(posedge clk);
    #1;
    en_a = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", 64'(busy_a), 0);
    n_v = 0;
    repeat (1500) begin
      @(posedge clk);
      #1;
      if (valid_a === 1'b1 || busy_a === 1'b1) n_v++;
    end
    chk("abort_no_valid", 64'(n_v), 0);
    chk("abort_keep_freq", 64'(freq_a), 100);

    // Re-enable: first result exactly one window later
    en_a = 1'b1;
    @(posedge clk);
    #1;
    n = 0;
    while (valid_a !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reenable_latency", 64'(n), 64'(GA + LAT_A));
    chk("reenable_freq", 64'(freq_a), 100);

    // Asynchronous reset in the middle of a window
    repeat (300) @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("midrst_freq_a", 64'(freq_a), 0);
    chk("midrst_busy_a", 64'(busy_a), 0);
    chk("midrst_valid_a", 64'(valid_a), 0);
    chk("midrst_freq_b", 64'(freq_b), 0);
    chk("midrst_ovf_b", 64'(ovf_b), 0);
    en_a = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    n_v = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (valid_a === 1'b1 || busy_a === 1'b1) n_v++;
    end
    chk("post_rst_quiet", 64'(n_v), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
